pc_sequencer: RTL and testbench

- Multi-cycle control FSM that sequences the program counter: drives its start/halt/branch/jump controls and next-address bus.
- Sits between instruction decode/ALU flags and the PC register.
- Owns fetch handshake, instruction retire, branch/jump target arithmetic and end-of-program detection.
- The PC register computes next_addr_pc+1 on plain advance and loads next_addr_pc on branch/jump.

---
 rtl/pc_sequencer.sv | 125 ++++++++++++
 tb/tb_pc_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch/execute control FSM driving PC load/hold commands.
// Optional single-step mode (PAUSE state, step input) is enabled by defining SINGLE_STEP_EN.
module pc_sequencer #(
  parameter int AW   = 16,
  parameter int OFFW = 8,
  parameter int CW   = 16
) (
  input  logic                   clk,
  input  logic                   start,
  input  logic                   go,
  input  logic                   instr_valid,
  input  logic                   is_halt,
  input  logic                   is_branch,
  input  logic                   br_cond,
  input  logic                   is_jump,
  input  logic signed [OFFW-1:0] br_offset,
  input  logic [AW-1:0]          jump_target,
  input  logic                   exec_busy,
  input  logic [AW-1:0]          pc_cur,
  output logic                   start_pc,
  output logic                   halt_pc,
  output logic                   br_taken_pc,
  output logic                   j_taken_pc,
  output logic [AW-1:0]          next_addr_pc,
  output logic                   fetch_req,
  output logic                   done,
  output logic [CW-1:0]          instr_count,
`ifdef SINGLE_STEP_EN
  input  logic                   step,
  output logic [2:0]             state_o
`else
  output logic [1:0]             state_o
`endif
);

`ifdef SINGLE_STEP_EN
  localparam int SW = 3;
  typedef enum logic [SW-1:0] {IDLE = 3'd0, FETCH = 3'd1, EXEC = 3'd2, DONE = 3'd3,
                               PAUSE = 3'd4} state_t;
`else
  localparam int SW = 2;
  typedef enum logic [SW-1:0] {IDLE = 2'd0, FETCH = 2'd1, EXEC = 2'd2, DONE = 2'd3} state_t;
`endif

  state_t               state_q;
  state_t               state_d;
  logic                 retire;
  logic [CW-1:0]        count_q;
  logic signed [AW-1:0] br_off_ext;
  logic [AW-1:0]        br_target;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign br_off_ext = {{(AW-OFFW){br_offset[OFFW-1]}}, br_offset};
  assign br_target  = pc_cur + br_off_ext;

  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    start_pc     = 1'b0;
    halt_pc      = 1'b1;
    br_taken_pc  = 1'b0;
    j_taken_pc   = 1'b0;
    next_addr_pc = pc_cur;
    fetch_req    = 1'b0;
    done         = 1'b0;
    if (start) begin
      // Restart overrides everything, including an in-flight retire.
      start_pc = 1'b1;
      halt_pc  = 1'b0;
      state_d  = IDLE;
    end else begin
      case (state_q)
        IDLE: if (go) state_d = FETCH;
        FETCH: begin
          fetch_req = 1'b1;
          if (instr_valid) state_d = EXEC;
        end
        EXEC: begin
          if (!exec_busy) begin
            retire = 1'b1;
            if (is_halt) begin
              state_d = DONE;
            end else begin
              halt_pc = 1'b0;
`ifdef SINGLE_STEP_EN
              state_d = PAUSE;
`else
              state_d = FETCH;
`endif
              if (is_jump) begin
                j_taken_pc   = 1'b1;
                next_addr_pc = jump_target;
              end else if (is_branch && br_cond) begin
                br_taken_pc  = 1'b1;
                next_addr_pc = br_target;
              end
            end
          end
        end
        DONE: done = 1'b1;
`ifdef SINGLE_STEP_EN
        PAUSE: if (step) state_d = FETCH;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) count_q <= sat_inc(count_q);
    end
  end

  assign instr_count = count_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: driver pushes expected retires, monitor pops and compares.
module tb_pc_sequencer;
  localparam int AW = 16, OFFW = 8, CW = 5;
  localparam logic [CW-1:0] CMAX = '1;

  logic clk = 0;
  logic start = 0, go = 0, instr_valid = 0, is_halt = 0, is_branch = 0, br_cond = 0;
  logic is_jump = 0, exec_busy = 0;
  logic signed [OFFW-1:0] br_offset = '0;
  logic [AW-1:0] jump_target = '0, pc_reg = '0;
  logic start_pc, halt_pc, br_taken_pc, j_taken_pc, fetch_req, done;
  logic [AW-1:0] next_addr_pc;
  logic [CW-1:0] instr_count;
`ifdef SINGLE_STEP_EN
  logic step = 1'b1;
  logic [2:0] state_o;
`else
  logic [1:0] state_o;
`endif

  pc_sequencer #(.AW(AW), .OFFW(OFFW), .CW(CW)) dut (
    .clk(clk), .start(start), .go(go), .instr_valid(instr_valid), .is_halt(is_halt),
    .is_branch(is_branch), .br_cond(br_cond), .is_jump(is_jump), .br_offset(br_offset),
    .jump_target(jump_target), .exec_busy(exec_busy), .pc_cur(pc_reg),
    .start_pc(start_pc), .halt_pc(halt_pc), .br_taken_pc(br_taken_pc),
    .j_taken_pc(j_taken_pc), .next_addr_pc(next_addr_pc), .fetch_req(fetch_req),
    .done(done), .instr_count(instr_count),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .state_o(state_o));

  always #5 clk = ~clk;

  // Environment PC register, steered only by the sequencer's commands.
  always @(posedge clk) begin
    if (start_pc) pc_reg <= '0;
    else if (!halt_pc) pc_reg <= (br_taken_pc || j_taken_pc) ? next_addr_pc : next_addr_pc + 1'b1;
  end

  typedef enum int {K_PLAIN, K_BRNT, K_BRT, K_JUMP, K_HALT} kind_t;
  typedef struct {
    kind_t         k;
    logic [AW-1:0] addr;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int n_chk = 0, n_pass = 0;
  logic [AW-1:0] model_pc = '0;
  int model_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every advance cycle and every entry into DONE must match the next expected retire.
  initial begin
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!start_pc && !halt_pc) begin
        if (exp_q.size() == 0) chk("unexpected_advance", 32'(next_addr_pc), 32'hDEAD);
        else begin
          e = exp_q.pop_front();
          chk("adv_j_taken", 32'(j_taken_pc), 32'(e.k == K_JUMP));
          chk("adv_br_taken", 32'(br_taken_pc), 32'(e.k == K_BRT));
          chk("adv_next_addr", 32'(next_addr_pc), 32'(e.addr));
          chk("adv_count", 32'(instr_count), 32'(e.cnt));
        end
      end
      if (done && !done_prev) begin
        if (exp_q.size() == 0) chk("unexpected_done", 32'(done), 32'h0);
        else begin
          e = exp_q.pop_front();
          chk("done_is_halt_retire", 32'(e.k == K_HALT), 32'h1);
          chk("halt_count", 32'(instr_count), 32'(e.cnt));
        end
      end
      done_prev = done;
    end
  end

  task automatic pulse_start();
    start = 1; go = 0;
    @(negedge clk);
    chk("rst_start_pc", 32'(start_pc), 32'h1);
    chk("rst_cmds", 32'({halt_pc, br_taken_pc, j_taken_pc, fetch_req, done}), 32'h0);
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    chk("rst_state", 32'(state_o), 32'h0);
    chk("rst_count", 32'(instr_count), 32'h0);
    chk("idle_hold", 32'({halt_pc, fetch_req, done}), 32'b100);
    model_pc = '0;
    model_cnt = 0;
  endtask

  task automatic pulse_go();
    @(posedge clk); #1;
    go = 1;
    @(posedge clk); #1;
    go = 0;
  endtask

  task automatic wait_fetch(output bit ok);
    ok = 0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (fetch_req) begin ok = 1; return; end
      @(posedge clk); #1;
    end
    chk("fetch_timeout", 32'(fetch_req), 32'h1);
  endtask

  task automatic run_instr(input kind_t k, input logic [7:0] off, input logic [AW-1:0] tgt,
                           input int sf, input int se);
    bit ok;
    exp_t e;
    int offi;
    wait_fetch(ok);
    if (!ok) return;
    chk("fetch_pc", 32'(pc_reg), 32'(model_pc));
    for (int i = 0; i < sf; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("fetch_stall_hold", 32'({fetch_req, halt_pc}), 32'b11);
    end
    instr_valid = 1;
    @(posedge clk); #1;
    instr_valid = 0;
    is_halt   = (k == K_HALT);
    is_jump   = (k == K_JUMP) || (k == K_HALT && $urandom_range(0, 1) == 1);
    is_branch = (k == K_BRT) || (k == K_BRNT) ||
                ((k == K_JUMP || k == K_HALT) && $urandom_range(0, 1) == 1);
    br_cond   = (k == K_BRT) || ((k != K_BRNT) && $urandom_range(0, 1) == 1);
    br_offset = off;
    jump_target = tgt;
    exec_busy = (se > 0);
    for (int i = 0; i < se; i++) begin
      @(negedge clk);
      chk("exec_stall_hold", 32'({halt_pc, fetch_req, j_taken_pc, br_taken_pc}), 32'b1000);
      @(posedge clk); #1;
      if (i == se - 1) exec_busy = 0;
    end
    offi = int'($signed(off));
    e.k = k;
    case (k)
      K_JUMP:  e.addr = tgt;
      K_BRT:   e.addr = AW'(int'(model_pc) + offi);
      default: e.addr = model_pc;
    endcase
    if (k == K_HALT) begin
      model_cnt = (model_cnt < int'(CMAX)) ? model_cnt + 1 : model_cnt;
      e.cnt = CW'(model_cnt);
    end else begin
      e.cnt = CW'(model_cnt);
      model_cnt = (model_cnt < int'(CMAX)) ? model_cnt + 1 : model_cnt;
      model_pc = (k == K_PLAIN || k == K_BRNT) ? model_pc + 1'b1 : e.addr;
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    {is_halt, is_jump, is_branch, br_cond} = '0;
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++)
      run_instr(kind_t'($urandom_range(0, 3)), 8'($urandom), AW'($urandom),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
  endtask

  task automatic check_done();
    @(negedge clk);
    chk("done_flag", 32'({done, halt_pc, fetch_req}), 32'b110);
    chk("done_state", 32'(state_o), 32'h3);
    chk("halt_pc_unchanged", 32'(pc_reg), 32'(model_pc));
    go = 1;
    repeat (3) @(posedge clk);
    #1 go = 0;
    @(negedge clk);
    chk("go_ignored_in_done", 32'({state_o, done}), 32'({2'd3, 1'b1}));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    repeat (2) @(posedge clk); #1;
    pulse_start();
    pulse_go();
    repeat (3) run_instr(K_PLAIN, 8'h00, '0, 0, 0);
    run_instr(K_JUMP, 8'h00, 16'h0005, 0, 0);
    run_instr(K_BRT, 8'hFD, '0, 0, 0);
    run_instr(K_JUMP, 8'h00, 16'h0005, 0, 0);
    run_instr(K_BRNT, 8'hFD, '0, 0, 0);
    run_instr(K_JUMP, 8'h00, 16'h0040, 0, 0);
    run_instr(K_PLAIN, 8'h00, '0, 4, 3);
    run_instr(K_JUMP, 8'h00, 16'hFFFF, 0, 0);
    run_instr(K_BRT, 8'h02, '0, 0, 0);
    run_instr(K_JUMP, 8'h00, 16'hFFFF, 0, 0);
    run_instr(K_PLAIN, 8'h00, '0, 1, 1);
    run_random(30);
    run_instr(K_HALT, 8'h00, 16'h1234, 0, 1);
    check_done();

    // Restart, retire one, then abort mid-execute with the core stalled.
    pulse_start();
    pulse_go();
    run_instr(K_PLAIN, 8'h00, '0, 0, 0);
    wait_fetch(ok);
    instr_valid = 1;
    @(posedge clk); #1;
    instr_valid = 0;
    exec_busy = 1;
    @(negedge clk);
    chk("abort_in_exec", 32'(state_o), 32'h2);
    chk("count_before_abort", 32'(instr_count), 32'h1);
    start = 1;
    #1;
    chk("abort_start_pc", 32'({start_pc, halt_pc, fetch_req, br_taken_pc, j_taken_pc}), 32'b10000);
    @(posedge clk); #1;
    start = 0; exec_busy = 0;
    @(negedge clk);
    chk("abort_state", 32'(state_o), 32'h0);
    chk("abort_count", 32'(instr_count), 32'h0);
    model_pc = '0;
    model_cnt = 0;

    pulse_go();
    run_random(8);
    run_instr(K_HALT, 8'h00, '0, 1, 0);
    check_done();
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
